// File: rtl/maze_tile_fetch.sv
// maze_tile_fetch: front end of the maze renderer. Splits each screen pixel into
// a maze cell and a 4-bit in-tile offset. It then reads the cell's wall nibble
// from synchronous maze RAM, drives the wall_layout stage, and registers its
// answer as the rendered pixel.
//
// This is a 3-stage streaming pipeline with no backpressure. Bubbles travel
// through the pipeline as empty slots.
//
// Optional feature: define MAZE_CURSOR_EN to add the cursor_col/cursor_row
// ports. When enabled, pixels that fall in the highlighted cell are inverted.
module maze_tile_fetch #(
  parameter int MAZE_W = 16,
  parameter int MAZE_H = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic [11:0]       pix_x,
  input  logic [11:0]       pix_y,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [3:0]        ram_rdata,
  output logic [3:0]        tile_x,
  output logic [3:0]        tile_y,
  output logic              wall_l,
  output logic              wall_t,
  output logic              wall_r,
  output logic              wall_b,
  input  logic              wl_value,
  output logic              pix_out,
  output logic              pix_out_vld
`ifdef MAZE_CURSOR_EN
  ,
  input  logic [7:0]        cursor_col,
  input  logic [7:0]        cursor_row
`endif
);

  logic [7:0]        col;
  logic [7:0]        row;
  logic              in_maze;
  logic              fetch;
  logic [ADDR_W-1:0] cell_addr;
  logic              s1_valid;
  logic [3:0]        s1_off_x;
  logic [3:0]        s1_off_y;
  logic              s2_valid;
  logic              s2_in_maze;
  logic              invert;

  // Split the incoming pixel into a cell and decide whether the cell lies inside the maze
  always_comb begin
    col       = pix_x[11:4];
    row       = pix_y[11:4];
    in_maze   = (32'(col) < 32'(MAZE_W)) && (32'(row) < 32'(MAZE_H));
    fetch     = pix_valid & in_maze;
    cell_addr = ADDR_W'(32'(row) * 32'(MAZE_W) + 32'(col));
  end

  // Stage 1: issue the RAM read and carry the in-tile offsets alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_off_x  <= 4'd0;
      s1_off_y  <= 4'd0;
    end else begin
      ram_rd_en <= fetch;
      ram_addr  <= fetch ? cell_addr : '0;
      s1_valid  <= pix_valid;
      s1_off_x  <= pix_valid ? pix_x[3:0] : 4'd0;
      s1_off_y  <= pix_valid ? pix_y[3:0] : 4'd0;
    end
  end

  // Stage 2: present the tile offsets while the RAM returns the wall nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_x     <= 4'd0;
      tile_y     <= 4'd0;
      s2_valid   <= 1'b0;
      s2_in_maze <= 1'b0;
    end else begin
      tile_x     <= s1_off_x;
      tile_y     <= s1_off_y;
      s2_valid   <= s1_valid;
      s2_in_maze <= ram_rd_en;
    end
  end

  // Read data is only meaningful in slots that actually fetched a cell
  always_comb begin
    {wall_l, wall_t, wall_r, wall_b} = s2_in_maze ? ram_rdata : 4'b0000;
  end

`ifdef MAZE_CURSOR_EN
  logic s1_hit;
  logic s2_hit;

  // Cursor match is decided on the raw pixel and travels with its slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit <= 1'b0;
      s2_hit <= 1'b0;
    end else begin
      s1_hit <= fetch && (col == cursor_col) && (row == cursor_row);
      s2_hit <= s1_hit;
    end
  end

  assign invert = s2_hit;
`else
  assign invert = 1'b0;
`endif

  // Stage 3: capture the wall_layout answer as the rendered pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out     <= 1'b0;
      pix_out_vld <= 1'b0;
    end else begin
      pix_out     <= s2_in_maze & (wl_value ^ invert);
      pix_out_vld <= s2_valid;
    end
  end

endmodule

// File: tb/tb_maze_tile_fetch.sv
// tb_maze_tile_fetch: drives maze_tile_fetch against a behavioural maze model.
// A monitor compares every pixel the DUT presents against a queue of expected
// pixels.
module tb_maze_tile_fetch;

  localparam int MW = 16;
  localparam int MH = 16;
  localparam int AW = 8;
  localparam int CUR_COL = 2;
  localparam int CUR_ROW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic [11:0]   pix_x = '0;
  logic [11:0]   pix_y = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_rdata = '0;
  logic [3:0]    tile_x;
  logic [3:0]    tile_y;
  logic          wall_l;
  logic          wall_t;
  logic          wall_r;
  logic          wall_b;
  logic          wl_value;
  logic          pix_out;
  logic          pix_out_vld;
`ifdef MAZE_CURSOR_EN
  logic [7:0]    cursor_col = 8'(CUR_COL);
  logic [7:0]    cursor_row = 8'(CUR_ROW);
`endif

  typedef struct {
    int   cyc;
    logic pix;
    int   x;
    int   y;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mem [256];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  maze_tile_fetch #(.MAZE_W(MW), .MAZE_H(MH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr),
    .ram_rdata(ram_rdata),
    .tile_x(tile_x),
    .tile_y(tile_y),
    .wall_l(wall_l),
    .wall_t(wall_t),
    .wall_r(wall_r),
    .wall_b(wall_b),
    .wl_value(wl_value),
    .pix_out(pix_out),
    .pix_out_vld(pix_out_vld)
`ifdef MAZE_CURSOR_EN
    ,
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous maze RAM; slots without a read return junk so ignored data shows up
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
    else           ram_rdata <= 4'($urandom);
  end

  // Stand-in wall_layout: depends on offsets and every wall bit
  function automatic logic wl_func(input logic [3:0] tx, input logic [3:0] ty,
                                   input logic [3:0] walls);
    return walls[tx[1:0]] ^ ty[0] ^ (tx[3] & ty[3]);
  endfunction

  assign wl_value = wl_func(tile_x, tile_y, {wall_l, wall_t, wall_r, wall_b});

  // Reference: pixel -> cell by division, look up the maze, ask wall_layout
  function automatic logic model_pix(input int x, input int y);
    int   c;
    int   r;
    logic v;
    c = x / 16;
    r = y / 16;
    if (c >= MW || r >= MH) return 1'b0;
    v = wl_func(4'(x % 16), 4'(y % 16), mem[r * MW + c]);
`ifdef MAZE_CURSOR_EN
    if (c == CUR_COL && r == CUR_ROW) v = ~v;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one slot at the falling edge, queue its expected pixel, advance a cycle
  task automatic applyStimulus(input logic v, input int x, input int y);
    exp_t e;
    pix_valid = v;
    pix_x     = 12'(x);
    pix_y     = 12'(y);
    if (v) begin
      e.cyc = cyc + 3;
      e.pix = model_pix(x, y);
      e.x   = x;
      e.y   = y;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {20'd0, ram_rd_en, ram_addr, tile_x, tile_y, wall_l, wall_t,
                       wall_r, wall_b, pix_out, pix_out_vld}, 32'd0);
  endtask

  // Monitor: pop and compare whenever a pixel comes out, otherwise expect a clean bubble
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pix_out_vld) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pix_out_vld", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("pix_out(x=%0d,y=%0d)", e.x, e.y), 32'(pix_out), 32'(e.pix));
          checkOutput("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        checkOutput("bubble_pix_out", 32'(pix_out), 32'd0);
      end
    end
  end

  // Directed cases, mid-stream reset, long stream, then randomized traffic
  initial begin
    int x;
    int y;
    int waited;
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom);
    mem[8'h42] = 4'b1010;
    mem[8'h43] = 4'b1010;

    repeat (3) @(negedge clk);
    checkAllZero("reset_state");
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 0);

    // In-maze pixel: cell (2,4), offsets (3,5)
    applyStimulus(1'b1, 'h023, 'h045);
    checkOutput("t2_ram_rd_en", 32'(ram_rd_en), 32'd1);
    checkOutput("t2_ram_addr", 32'(ram_addr), 32'h42);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t2_tile_xy", {24'd0, tile_x, tile_y}, 32'h35);
    checkOutput("t2_walls", {28'd0, wall_l, wall_t, wall_r, wall_b}, 32'b1010);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t2_pix_out_vld", 32'(pix_out_vld), 32'd1);

    // Column just past the right edge, then row just past the bottom
    applyStimulus(1'b1, 'h10A, 'h013);
    checkOutput("t3_ram_rd_en", 32'(ram_rd_en), 32'd0);
    checkOutput("t3_ram_addr", 32'(ram_addr), 32'd0);
    applyStimulus(1'b1, 'h020, 'h100);
    checkOutput("t3_tile_xy", {24'd0, tile_x, tile_y}, 32'hA3);
    checkOutput("t3_walls", {28'd0, wall_l, wall_t, wall_r, wall_b}, 32'd0);
    checkOutput("t3b_ram_rd_en", 32'(ram_rd_en), 32'd0);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t3b_walls", {28'd0, wall_l, wall_t, wall_r, wall_b}, 32'd0);
    applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b0, 0, 0);

    // Reset in the middle of a burst drops everything in flight
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    #1;
    checkAllZero("midreset_outputs");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 0, 0);
      checkOutput("post_reset_idle_vld", 32'(pix_out_vld), 32'd0);
    end

    // Row of 256 pixels at y=0 with one bubble ahead of x=100
    for (int i = 0; i < 256; i++) begin
      if (i == 100) applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b1, i, 0);
    end

`ifdef MAZE_CURSOR_EN
    // Cursor cell inverts; the neighbouring cell does not
    applyStimulus(1'b1, 'h021, 'h040);
    applyStimulus(1'b1, 'h031, 'h040);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t5_cursor_cell", 32'(pix_out), 32'd0);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t5_neighbour_cell", 32'(pix_out), 32'd1);
`endif

    // Randomized traffic: mostly near the maze, occasionally anywhere on screen
    for (int i = 0; i < 600; i++) begin
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 'h11F));
      y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 'h11F));
      applyStimulus($urandom_range(0, 3) != 0, x, y);
    end

    pix_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
